// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between the execute stage (port 0) and the debug unit (port 1).
// Optional MUL_MULTICYCLE_EN: opcode 3'b101 occupies the ALU for MUL_CYCLES EXEC cycles.
module alu_share_arbiter #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [WIDTH-1:0] req0_data1_i,
    input  logic [WIDTH-1:0] req0_data2_i,
    input  logic [2:0]       req0_ctrl_i,
    output logic             resp0_valid_o,
    input  logic             resp0_ready_i,

    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [WIDTH-1:0] req1_data1_i,
    input  logic [WIDTH-1:0] req1_data2_i,
    input  logic [2:0]       req1_ctrl_i,
    output logic             resp1_valid_o,
    input  logic             resp1_ready_i,

    output logic [WIDTH-1:0] resp_data_o,

    output logic [WIDTH-1:0] alu_data1_o,
    output logic [WIDTH-1:0] alu_data2_o,
    output logic [2:0]       alu_ctrl_o,
    input  logic [WIDTH-1:0] alu_data_i,

    output logic             busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL = 3'b101;

    if (MUL_CYCLES < 2 || MUL_CYCLES > 15) begin : g_bad_mul_cycles
        $error("alu_share_arbiter: MUL_CYCLES must be in 2..15");
    end

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic             owner;
    logic [WIDTH-1:0] op_data1;
    logic [WIDTH-1:0] op_data2;
    logic [2:0]       op_ctrl;
    logic [WIDTH-1:0] result;

    logic             grant_valid;
    logic             grant_port;
    logic             accept;
    logic             exec_last;
    logic             owner_resp_ready;
    logic [WIDTH-1:0] sel_data1;
    logic [WIDTH-1:0] sel_data2;
    logic [2:0]       sel_ctrl;

    // Contention goes to the port that did not win last; a lone requester always wins.
    always_comb begin
        grant_valid = req0_valid_i | req1_valid_i;
        grant_port  = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            grant_port = ~last_grant;
        end else if (req1_valid_i) begin
            grant_port = 1'b1;
        end
    end

    assign accept       = (state == IDLE) && grant_valid;
    assign req0_ready_o = accept && !grant_port;
    assign req1_ready_o = accept &&  grant_port;

    assign sel_data1 = grant_port ? req1_data1_i : req0_data1_i;
    assign sel_data2 = grant_port ? req1_data2_i : req0_data2_i;
    assign sel_ctrl  = grant_port ? req1_ctrl_i  : req0_ctrl_i;

    assign owner_resp_ready = owner ? resp1_ready_i : resp0_ready_i;

`ifdef MUL_MULTICYCLE_EN
    logic [3:0] exec_count;

    assign exec_last = (exec_count <= 4'd1);

    // Remaining EXEC cycles, loaded at the handshake so the ALU inputs stay frozen for MUL.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            exec_count <= 4'd0;
        end else if (accept) begin
            exec_count <= (sel_ctrl == OP_MUL) ? 4'(MUL_CYCLES) : 4'd1;
        end else if (state == EXEC && !exec_last) begin
            exec_count <= exec_count - 4'd1;
        end
    end
`else
    assign exec_last = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (exec_last) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (owner_resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset drops any in-flight operation, so the result register is cleared as well.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_data1   <= '0;
            op_data2   <= '0;
            op_ctrl    <= 3'b000;
            result     <= '0;
        end else begin
            if (accept) begin
                op_data1   <= sel_data1;
                op_data2   <= sel_data2;
                op_ctrl    <= sel_ctrl;
                owner      <= grant_port;
                last_grant <= grant_port;
            end
            if (state == EXEC && exec_last) begin
                result <= alu_data_i;
            end
        end
    end

    assign alu_data1_o   = op_data1;
    assign alu_data2_o   = op_data2;
    assign alu_ctrl_o    = (state == EXEC) ? op_ctrl : 3'b000;
    assign resp_data_o   = result;
    assign resp0_valid_o = (state == RESP) && !owner;
    assign resp1_valid_o = (state == RESP) &&  owner;
    assign busy_o        = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for each scenario. Honours MUL_MULTICYCLE_EN like the design.
module tb_alu_share_arbiter;

    localparam int WIDTH      = 32;
    localparam int MUL_CYCLES = 3;

    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PASS = 3'b110;
    localparam logic [2:0] OP_BAD  = 3'b111;

    logic             clk_i;
    logic             rst_i;
    logic             req0_valid_i, req0_ready_o, resp0_valid_o, resp0_ready_i;
    logic             req1_valid_i, req1_ready_o, resp1_valid_o, resp1_ready_i;
    logic [WIDTH-1:0] req0_data1_i, req0_data2_i, req1_data1_i, req1_data2_i;
    logic [2:0]       req0_ctrl_i, req1_ctrl_i;
    logic [WIDTH-1:0] resp_data_o, alu_data1_o, alu_data2_o, alu_data_i;
    logic [2:0]       alu_ctrl_o;
    logic             busy_o;

    int checks = 0;
    int errors = 0;

    alu_share_arbiter #(.WIDTH(WIDTH), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_data1_i(req0_data1_i), .req0_data2_i(req0_data2_i), .req0_ctrl_i(req0_ctrl_i),
        .resp0_valid_o(resp0_valid_o), .resp0_ready_i(resp0_ready_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_data1_i(req1_data1_i), .req1_data2_i(req1_data2_i), .req1_ctrl_i(req1_ctrl_i),
        .resp1_valid_o(resp1_valid_o), .resp1_ready_i(resp1_ready_i),
        .resp_data_o(resp_data_o),
        .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_ctrl_o(alu_ctrl_o),
        .alu_data_i(alu_data_i),
        .busy_o(busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Stand-in for the CPU's ALU; opcodes 000 and 111 produce 0.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] c);
        case (c)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            OP_PASS: return a;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_data_i = alu_fn(alu_data1_o, alu_data2_o, alu_ctrl_o);

    function automatic int exec_len(input logic [2:0] c);
`ifdef MUL_MULTICYCLE_EN
        return (c == OP_MUL) ? MUL_CYCLES : 1;
`else
        return (c == OP_MUL) ? 1 : 1;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit port, input logic valid, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic [2:0] c);
        if (!port) begin
            req0_valid_i = valid; req0_data1_i = d1; req0_data2_i = d2; req0_ctrl_i = c;
        end else begin
            req1_valid_i = valid; req1_data1_i = d1; req1_data2_i = d2; req1_ctrl_i = c;
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Transaction model: one operation in flight, described by its owner, operands and the
    // number of ALU cycles still to run (0 = result waiting for the owner to take it).
    bit          m_ok = 1'b0;
    bit          m_busy, m_owner, m_last;
    int          m_left;
    logic [31:0] m_a, m_b, m_result;
    logic [2:0]  m_ctrl;

    always @(negedge clk_i) begin : compare_proc
        logic exp_r0, exp_r1, gp;
        if (m_ok) begin
            exp_r0 = !m_busy && req0_valid_i && (!req1_valid_i || m_last);
            exp_r1 = !m_busy && req1_valid_i && (!req0_valid_i || !m_last);
            checkOutput("req0_ready",  32'(req0_ready_o),  32'(exp_r0));
            checkOutput("req1_ready",  32'(req1_ready_o),  32'(exp_r1));
            checkOutput("ready_excl",  32'(req0_ready_o & req1_ready_o), 32'd0);
            checkOutput("resp0_valid", 32'(resp0_valid_o), 32'(m_busy && m_left == 0 && !m_owner));
            checkOutput("resp1_valid", 32'(resp1_valid_o), 32'(m_busy && m_left == 0 && m_owner));
            checkOutput("resp_data",   resp_data_o, m_result);
            checkOutput("alu_data1",   alu_data1_o, m_a);
            checkOutput("alu_data2",   alu_data2_o, m_b);
            checkOutput("alu_ctrl",    32'(alu_ctrl_o), 32'((m_busy && m_left > 0) ? m_ctrl : 3'b000));
            checkOutput("busy",        32'(busy_o), 32'(m_busy));
        end
        if (!rst_i) begin
            m_ok = 1'b1; m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_left = 0;
            m_a = '0; m_b = '0; m_ctrl = 3'b000; m_result = '0;
        end else if (m_ok) begin
            if (!m_busy) begin
                if (req0_valid_i || req1_valid_i) begin
                    gp = (req0_valid_i && req1_valid_i) ? !m_last : req1_valid_i;
                    m_a    = gp ? req1_data1_i : req0_data1_i;
                    m_b    = gp ? req1_data2_i : req0_data2_i;
                    m_ctrl = gp ? req1_ctrl_i  : req0_ctrl_i;
                    m_busy = 1'b1; m_owner = gp; m_last = gp;
                    m_left = exec_len(m_ctrl);
                end
            end else if (m_left > 0) begin
                if (m_left == 1) m_result = alu_fn(m_a, m_b, m_ctrl);
                m_left--;
            end else if (m_owner ? resp1_ready_i : resp0_ready_i) begin
                m_busy = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int g0, g1, r0, r1;
        rst_i = 1'b0;
        resp0_ready_i = 1'b0; resp1_ready_i = 1'b0;
        applyStimulus(0, 1'b0, 0, 0, 3'b000);
        applyStimulus(1, 1'b0, 0, 0, 3'b000);
        step(); step();
        rst_i = 1'b1;
        checkOutput("rst_busy", 32'(busy_o), 0);
        checkOutput("rst_resp_data", resp_data_o, 0);
        checkOutput("rst_alu_ctrl", 32'(alu_ctrl_o), 0);

        $display("[TB] ADD 5,7 on port 0");
        applyStimulus(0, 1'b1, 5, 7, OP_ADD);
        #1;
        checkOutput("add_ready0", 32'(req0_ready_o), 1);
        checkOutput("add_ready1", 32'(req1_ready_o), 0);
        step();
        applyStimulus(0, 1'b0, 32'h1234, 32'h5678, OP_SUB);
        checkOutput("add_busy_exec", 32'(busy_o), 1);
        checkOutput("add_alu_ctrl", 32'(alu_ctrl_o), 32'(OP_ADD));
        step();
        checkOutput("add_resp_valid", 32'(resp0_valid_o), 1);
        checkOutput("add_resp_data", resp_data_o, 12);
        checkOutput("add_alu_ctrl_resp", 32'(alu_ctrl_o), 0);
        step();
        resp0_ready_i = 1'b1;
        checkOutput("add_busy_third", 32'(busy_o), 1);
        step();
        checkOutput("add_idle", 32'(busy_o), 0);

        $display("[TB] both ports requesting continuously");
        resp1_ready_i = 1'b1;
        applyStimulus(0, 1'b1, 10, 3, OP_SUB);
        applyStimulus(1, 1'b1, 32'hF0, 32'h0F, OP_OR);
        g0 = 0; g1 = 0; r0 = 0; r1 = 0;
        repeat (12) begin
            @(negedge clk_i);
            if (req0_ready_o) g0++;
            if (req1_ready_o) g1++;
            if (resp0_valid_o) begin r0++; checkOutput("sub_result", resp_data_o, 7); end
            if (resp1_valid_o) begin r1++; checkOutput("or_result", resp_data_o, 32'hFF); end
        end
        checkOutput("grants0", g0, 2);
        checkOutput("grants1", g1, 2);
        checkOutput("resps0", r0, 2);
        checkOutput("resps1", r1, 2);
        step();
        applyStimulus(0, 1'b0, 0, 0, 3'b000);
        applyStimulus(1, 1'b0, 0, 0, 3'b000);
        repeat (3) step();

        $display("[TB] port 1 AND with stalled response");
        resp1_ready_i = 1'b0;
        applyStimulus(1, 1'b1, 32'hFFFF0000, 32'h0F0F0F0F, OP_AND);
        #1;
        checkOutput("and_ready1", 32'(req1_ready_o), 1);
        step();
        applyStimulus(1, 1'b0, $urandom, $urandom, OP_SUB);
        applyStimulus(0, 1'b1, 1, 1, OP_ADD);
        step();
        repeat (5) begin
            checkOutput("hold_resp1_valid", 32'(resp1_valid_o), 1);
            checkOutput("hold_resp_data", resp_data_o, 32'h0F0F0000);
            checkOutput("hold_no_grant", 32'(req0_ready_o), 0);
            step();
        end
        resp1_ready_i = 1'b1;
        checkOutput("hold_still_valid", 32'(resp1_valid_o), 1);
        step();
        checkOutput("after_hold_ready0", 32'(req0_ready_o), 1);
        step();
        applyStimulus(0, 1'b0, 0, 0, 3'b000);
        repeat (3) step();

        $display("[TB] reset during EXEC and RESP");
        applyStimulus(0, 1'b1, 2, 3, OP_ADD);
        step();
        applyStimulus(0, 1'b0, 0, 0, 3'b000);
        checkOutput("rexec_busy_before", 32'(busy_o), 1);
        rst_i = 1'b0;
        step();
        rst_i = 1'b1;
        checkOutput("rexec_busy", 32'(busy_o), 0);
        checkOutput("rexec_resp0", 32'(resp0_valid_o), 0);
        checkOutput("rexec_resp1", 32'(resp1_valid_o), 0);
        checkOutput("rexec_data", resp_data_o, 0);
        resp0_ready_i = 1'b0;
        applyStimulus(0, 1'b1, 4, 4, OP_ADD);
        applyStimulus(1, 1'b1, 8, 8, OP_ADD);
        #1;
        checkOutput("rexec_grant0", 32'(req0_ready_o), 1);
        checkOutput("rexec_grant1", 32'(req1_ready_o), 0);
        step();
        applyStimulus(0, 1'b0, 0, 0, 3'b000);
        applyStimulus(1, 1'b0, 0, 0, 3'b000);
        step();
        checkOutput("rresp_valid_before", 32'(resp0_valid_o), 1);
        checkOutput("rresp_data_before", resp_data_o, 8);
        rst_i = 1'b0;
        step();
        rst_i = 1'b1;
        checkOutput("rresp_busy", 32'(busy_o), 0);
        checkOutput("rresp_resp0", 32'(resp0_valid_o), 0);
        checkOutput("rresp_data", resp_data_o, 0);
        applyStimulus(0, 1'b1, 1, 2, OP_ADD);
        applyStimulus(1, 1'b1, 3, 4, OP_ADD);
        #1;
        checkOutput("rresp_grant0", 32'(req0_ready_o), 1);
        checkOutput("rresp_grant1", 32'(req1_ready_o), 0);
        step();
        applyStimulus(0, 1'b0, 0, 0, 3'b000);
        applyStimulus(1, 1'b0, 0, 0, 3'b000);
        resp0_ready_i = 1'b1;
        repeat (3) step();

        $display("[TB] MUL 6,7 then ADD 20,30");
        applyStimulus(0, 1'b1, 6, 7, OP_MUL);
        step();
        applyStimulus(0, 1'b0, 0, 0, 3'b000);
        step();
`ifdef MUL_MULTICYCLE_EN
        checkOutput("mul_not_done", 32'(resp0_valid_o), 0);
        checkOutput("mul_ctrl_held", 32'(alu_ctrl_o), 32'(OP_MUL));
        step(); step();
`endif
        checkOutput("mul_resp_valid", 32'(resp0_valid_o), 1);
        checkOutput("mul_resp_data", resp_data_o, 42);
        repeat (2) step();
        applyStimulus(0, 1'b1, 20, 30, OP_ADD);
        step();
        applyStimulus(0, 1'b0, 0, 0, 3'b000);
        step();
        checkOutput("add2_resp_valid", 32'(resp0_valid_o), 1);
        checkOutput("add2_resp_data", resp_data_o, 50);
        repeat (2) step();

        $display("[TB] opcodes 111 and 110 on port 1");
        applyStimulus(1, 1'b1, 9, 9, OP_BAD);
        #1;
        checkOutput("bad_ctrl_idle", 32'(alu_ctrl_o), 0);
        step();
        applyStimulus(1, 1'b0, 0, 0, 3'b000);
        checkOutput("bad_ctrl_exec", 32'(alu_ctrl_o), 32'(OP_BAD));
        step();
        checkOutput("bad_resp_valid", 32'(resp1_valid_o), 1);
        checkOutput("bad_resp_data", resp_data_o, 0);
        checkOutput("bad_ctrl_resp", 32'(alu_ctrl_o), 0);
        step();
        applyStimulus(1, 1'b1, 32'hDEAD, 1, OP_PASS);
        step();
        applyStimulus(1, 1'b0, 0, 0, 3'b000);
        step();
        checkOutput("pass_resp_data", resp_data_o, 32'hDEAD);
        checkOutput("pass_ctrl_resp", 32'(alu_ctrl_o), 0);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
